// File: rtl/data_memory_lanes_if.sv
// data_memory_lanes_if: request/response bus of the byte-lane data memory.
interface data_memory_lanes_if #(parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_memory_lanes.sv
// data_memory_lanes: byte-lane data memory, one outstanding access, optional wait states.
module data_memory_lanes #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input logic clk,
    input logic rst,
    data_memory_lanes_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t            state;
    logic [3:0]        cnt;
    logic              wr;
    logic              uns;
    logic [1:0]        sz;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [IW-1:0]     idx;
    logic              oor;
    logic              err;
    logic              access;
    logic [3:0]        we;
    logic [31:0]       wd;
    logic [31:0]       rd;
    logic [31:0]       sh;
    logic [31:0]       ld;
    assign idx = addr[2+:IW];
    // Any set bit above the word index is out of range; DEPTH is a power of two.
    generate
        if (ADDR_W > IW + 2) begin : g_oor
            assign oor = |addr[ADDR_W-1:IW+2];
        end else begin : g_in
            assign oor = 1'b0;
        end
    endgenerate
    assign err = sz == 2'd3 || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0) || oor;
    assign access = state == WAIT && cnt == 4'd0;
    assign bus.req_ready = state == IDLE && !rst;
    always_comb begin
        we = (access && wr && !err && !rst) ?
             (sz == 2'd0 ? 4'b0001 << addr[1:0] : sz == 2'd1 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111) :
             4'b0000;
        wd = sz == 2'd0 ? {4{wdata[7:0]}} : sz == 2'd1 ? {2{wdata[15:0]}} : wdata;
        sh = rd >> {addr[1:0], 3'b000};
        ld = sz == 2'd0 ? {{24{sh[7] & !uns}}, sh[7:0]} :
             sz == 2'd1 ? {{16{sh[15] & !uns}}, sh[15:0]} : rd;
    end
    generate
        for (genvar i = 0; i < 4; i++) begin : g_lane
            logic [7:0] ram [DEPTH];
            always_ff @(posedge clk)
                if (we[i]) ram[idx] <= wd[8*i+:8];
            assign rd[8*i+:8] = ram[idx];
        end
    endgenerate
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'd0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            if (state == IDLE) begin
                if (bus.req_valid) begin
                    wr    <= bus.req_write;
                    sz    <= bus.req_size;
                    uns   <= bus.req_unsigned;
                    addr  <= bus.req_addr;
                    wdata <= bus.req_wdata;
                    cnt   <= 4'(WAIT_CYCLES);
                    state <= WAIT;
                end
            end else if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end else begin
                state         <= IDLE;
                bus.rsp_valid <= 1'b1;
                bus.rsp_err   <= err;
                bus.rsp_rdata <= (err || wr) ? 32'd0 : ld;
            end
        end
    end
endmodule

// File: tb/tb_data_memory_lanes.sv
// tb_data_memory_lanes: random and directed checks of two instances (0 and 3 wait states).
module tb_data_memory_lanes;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 32;
    typedef struct {
        logic w; logic [1:0] sz; logic u; logic [31:0] a; logic [31:0] d; logic [31:0] r; logic e;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic valid = 1'b0, write = 1'b0, uns = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic        rdy, rsp_v, rsp_e;
    logic [31:0] rsp_d;
    int checks = 0;
    int fails = 0;
    logic [7:0] mdl [2][DEPTH*4];
    vec_t dir [20] = '{
        '{1, 2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0},
        '{0, 2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0},
        '{1, 0, 0, 32'h13, 32'h00000080, 32'h0, 0},
        '{0, 0, 0, 32'h13, 32'h0, 32'hFFFFFF80, 0},
        '{0, 0, 1, 32'h13, 32'h0, 32'h00000080, 0},
        '{0, 2, 0, 32'h10, 32'h0, 32'h80ADBEEF, 0},
        '{1, 2, 0, 32'h20, 32'hAAAAAAAA, 32'h0, 0},
        '{1, 1, 0, 32'h22, 32'h00001234, 32'h0, 0},
        '{0, 2, 0, 32'h20, 32'h0, 32'h1234AAAA, 0},
        '{0, 1, 0, 32'h20, 32'h0, 32'hFFFFAAAA, 0},
        '{0, 1, 1, 32'h22, 32'h0, 32'h00001234, 0},
        '{1, 1, 0, 32'h21, 32'hFFFFFFFF, 32'h0, 1},
        '{1, 2, 0, 32'h22, 32'h55555555, 32'h0, 1},
        '{1, 3, 0, 32'h20, 32'h77777777, 32'h0, 1},
        '{1, 2, 0, DEPTH*4, 32'h66666666, 32'h0, 1},
        '{0, 2, 0, DEPTH*4, 32'h0, 32'h0, 1},
        '{1, 2, 0, 32'h10000010, 32'h99999999, 32'h0, 1},
        '{0, 2, 0, 32'h20, 32'h0, 32'h1234AAAA, 0},
        '{0, 2, 0, 32'h10, 32'h0, 32'h80ADBEEF, 0},
        '{0, 1, 0, 32'h21, 32'h0, 32'h0, 1}
    };
    data_memory_lanes_if #(.ADDR_W(ADDR_W)) b0 ();
    data_memory_lanes_if #(.ADDR_W(ADDR_W)) b3 ();
    assign b0.req_valid = valid & !sel;
    assign b3.req_valid = valid & sel;
    assign {b0.req_write, b0.req_size, b0.req_unsigned, b0.req_addr, b0.req_wdata} = {write, size, uns, addr, wdata};
    assign {b3.req_write, b3.req_size, b3.req_unsigned, b3.req_addr, b3.req_wdata} = {write, size, uns, addr, wdata};
    assign rdy   = sel ? b3.req_ready : b0.req_ready;
    assign rsp_v = sel ? b3.rsp_valid : b0.rsp_valid;
    assign rsp_d = sel ? b3.rsp_rdata : b0.rsp_rdata;
    assign rsp_e = sel ? b3.rsp_err   : b0.rsp_err;
    data_memory_lanes #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_CYCLES(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
    data_memory_lanes #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_CYCLES(3)) u3 (.clk(clk), .rst(rst), .bus(b3));
    always #5 clk = ~clk;
    // Byte-array reference: returns {err, rdata} and applies stores.
    function automatic logic [32:0] model(int s, logic w, logic [1:0] sz, logic u, logic [31:0] a, logic [31:0] d);
        int unsigned n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
        logic [31:0] r = 32'd0;
        if (sz == 2'd3 || a % n != 0 || a / 4 >= DEPTH) return {1'b1, 32'd0};
        for (int unsigned i = 0; i < n; i++)
            if (w) mdl[s][a+i] = d[8*i+:8];
            else r[8*i+:8] = mdl[s][a+i];
        if (w) return 33'd0;
        if (!u && n < 4 && r[8*n-1]) r = r | (32'hFFFFFFFF << (8*n));
        return {1'b0, r};
    endfunction
    task automatic do_req(input logic s, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d, input bit hold,
                          output logic [31:0] rd, output logic er, output int lat, output int low);
        int t = 0;
        @(negedge clk);
        sel = s; valid = 1'b1; write = w; size = sz; uns = u; addr = a; wdata = d;
        while (!rdy && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        if (!hold) begin
            valid = 1'b0;
            {write, size, uns} = 4'($urandom);
            addr = $urandom;
            wdata = $urandom;
        end
        lat = 1; low = 0;
        while (!rsp_v && lat < 50) begin
            if (!rdy) low++;
            @(negedge clk);
            lat++;
        end
        rd = rsp_d; er = rsp_e;
    endtask
    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({b0.req_ready, b0.rsp_valid, b0.rsp_err, b3.req_ready, b3.rsp_valid, b3.rsp_err} !== 6'b0 ||
            b0.rsp_rdata !== 32'd0 || b3.rsp_rdata !== 32'd0) begin
            fails++;
            $display("FAIL reset_state: ready0=%b v0=%b e0=%b d0=%h ready3=%b v3=%b e3=%b d3=%h, want all 0",
                     b0.req_ready, b0.rsp_valid, b0.rsp_err, b0.rsp_rdata, b3.req_ready, b3.rsp_valid, b3.rsp_err, b3.rsp_rdata);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({b0.req_ready, b3.req_ready} !== 2'b11) begin
            fails++;
            $display("FAIL reset_release_ready: got %b%b want 11", b0.req_ready, b3.req_ready);
        end
    endtask
    task automatic test_init;
        logic [31:0] rd, d; logic er; int lat, low;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH; i++) begin
                d = $urandom;
                void'(model(s, 1'b1, 2'd2, 1'b0, 32'(i*4), d));
                do_req(s[0], 1'b1, 2'd2, 1'b0, 32'(i*4), d, 1'b0, rd, er, lat, low);
                checks++;
                if (er !== 1'b0 || rd !== 32'd0 || lat != (s == 1 ? 5 : 2)) begin
                    fails++;
                    $display("FAIL init_store[%0d][%0d]: err=%b rdata=%h lat=%0d want 0 0 %0d", s, i, er, rd, lat, s == 1 ? 5 : 2);
                end
            end
    endtask
    task automatic test_directed;
        logic [31:0] rd; logic er; int lat, low;
        foreach (dir[i]) begin
            void'(model(0, dir[i].w, dir[i].sz, dir[i].u, dir[i].a, dir[i].d));
            do_req(1'b0, dir[i].w, dir[i].sz, dir[i].u, dir[i].a, dir[i].d, 1'b0, rd, er, lat, low);
            checks++;
            if (rd !== dir[i].r || er !== dir[i].e || lat != 2) begin
                fails++;
                $display("FAIL directed[%0d]: rdata=%h err=%b lat=%0d want %h %b 2", i, rd, er, lat, dir[i].r, dir[i].e);
            end
            checks++;
            if (rsp_v !== 1'b1) begin
                fails++;
                $display("FAIL directed_pulse[%0d]: rsp_valid=%b want 1", i, rsp_v);
            end
            @(negedge clk);
            checks++;
            if (rsp_v !== 1'b0) begin
                fails++;
                $display("FAIL directed_single_pulse[%0d]: rsp_valid=%b want 0", i, rsp_v);
            end
        end
    endtask
    task automatic test_random;
        logic [31:0] rd, a, d; logic [1:0] sz; logic w, u, er; logic [32:0] exp; int lat, low;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 200; i++) begin
                w = 1'($urandom); u = 1'($urandom); d = $urandom;
                sz = $urandom_range(0, 7) == 7 ? 2'd3 : 2'($urandom_range(0, 2));
                a = $urandom_range(0, 15) == 0 ? $urandom : $urandom_range(0, DEPTH*4 + 15);
                exp = model(s, w, sz, u, a, d);
                do_req(s[0], w, sz, u, a, d, 1'b0, rd, er, lat, low);
                checks++;
                if ({er, rd} !== exp || lat != (s == 1 ? 5 : 2) || low != (s == 1 ? 4 : 1)) begin
                    fails++;
                    $display("FAIL random[%0d][%0d] w=%b sz=%0d u=%b a=%h: err=%b rdata=%h lat=%0d low=%0d want %b %h %0d %0d",
                             s, i, w, sz, u, a, er, rd, lat, low, exp[32], exp[31:0], s == 1 ? 5 : 2, s == 1 ? 4 : 1);
                end
            end
    endtask
    task automatic test_back_to_back;
        logic [31:0] rd; logic er; int lat, low, n;
        logic [32:0] exp = model(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0);
        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 1'b1, rd, er, lat, low);
        checks++;
        if (low != 4 || lat != 5 || {er, rd} !== exp) begin
            fails++;
            $display("FAIL wait3_first: low=%0d lat=%0d err=%b rdata=%h want 4 5 %b %h", low, lat, er, rd, exp[32], exp[31:0]);
        end
        checks++;
        if (rdy !== 1'b1) begin
            fails++;
            $display("FAIL wait3_ready_with_rsp: ready=%b want 1", rdy);
        end
        @(negedge clk);
        valid = 1'b0;
        checks++;
        if (rsp_v !== 1'b0 || rdy !== 1'b0) begin
            fails++;
            $display("FAIL wait3_second_accept: rsp_valid=%b ready=%b want 0 0", rsp_v, rdy);
        end
        n = 1;
        while (!rsp_v && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (n != 5 || {rsp_e, rsp_d} !== exp) begin
            fails++;
            $display("FAIL wait3_second_rsp: lat=%0d err=%b rdata=%h want 5 %b %h", n, rsp_e, rsp_d, exp[32], exp[31:0]);
        end
    endtask
    task automatic test_reset_mid;
        logic [31:0] rd; logic er; int lat, low, t = 0;
        bit seen = 1'b0;
        logic [32:0] exp = model(1, 1'b0, 2'd2, 1'b0, 32'h44, 32'd0);
        @(negedge clk);
        sel = 1'b1; valid = 1'b1; write = 1'b1; size = 2'd2; addr = 32'h44; wdata = ~exp[31:0];
        while (!rdy && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        valid = 1'b0;
        rst = 1'b1;
        repeat (6) begin @(negedge clk); seen |= b0.rsp_valid | b3.rsp_valid; end
        checks++;
        if (seen) begin
            fails++;
            $display("FAIL reset_mid_no_rsp: rsp_valid seen=1 want 0");
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (b3.req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_ready: got %b want 1", b3.req_ready);
        end
        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h44, 32'd0, 1'b0, rd, er, lat, low);
        checks++;
        if ({er, rd} !== exp || lat != 5) begin
            fails++;
            $display("FAIL reset_mid_old_value: err=%b rdata=%h lat=%0d want %b %h 5", er, rd, lat, exp[32], exp[31:0]);
        end
    endtask
    initial begin
        test_reset;
        test_init;
        test_directed;
        test_random;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/data_memory_lanes.md
Name: data_memory_lanes

Overview:
Parametrised byte-lane data memory, the next generation of our single-cycle data memory. Serves one load/store at a time through a valid/ready request and a registered one-cycle response. Supports byte, halfword and word access with sign/zero extension, and adds configurable wait states and error reporting. Sits between the MEM stage and the memory map; the core stalls while `req_ready` is low.

Parameters:
- DEPTH, 256, number of 32-bit words; power of 2, minimum 4.
- ADDR_W, 32, byte-address width.
- WAIT_CYCLES, 0, extra cycles between request acceptance and the access edge; range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load result, valid with rsp_valid.
- rsp_err  out  1  request faulted, valid with rsp_valid.

Behaviour:
- Reset (rst high at an edge):
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, state IDLE.
  - req_ready=0 while rst is high; req_ready=1 in the first cycle after release.
  - Memory contents are not cleared.
- Storage: four 8-bit lanes of DEPTH entries. Little-endian: byte address A maps to word A[2+:log2(DEPTH)], lane A[1:0].
- States: IDLE, WAIT.
  - IDLE: req_ready=1. A request is accepted when req_valid && req_ready at edge T. All request fields are latched, then go to WAIT with the counter set to WAIT_CYCLES.
  - WAIT: req_ready=0. The counter decrements each edge. The edge where the counter equals 0 is the access edge, T+1+WAIT_CYCLES. At that edge: perform the access, register the response, return to IDLE.
  - rsp_valid is high for exactly the one cycle after the access edge. req_ready is high in that same cycle, so back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
- Input stability: request inputs are ignored when not accepted. Changes to them after acceptance have no effect.
- Error conditions (checked on latched values):
  - size 11;
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - addr[ADDR_W-1:2] ≥ DEPTH (out of range).
- On error: no lane is written, rsp_rdata=0, rsp_err=1.
- Store, no error:
  - byte writes lane addr[1:0] with wdata[7:0];
  - half writes lanes {addr[1],1} and {addr[1],0} with wdata[15:8] and wdata[7:0];
  - word writes all four lanes.
  - Other lanes are unchanged. rsp_rdata=0, rsp_err=0.
- Load, no error:
  - byte: selects lane addr[1:0], extended to 32 bits per req_unsigned.
  - half: selects the lane pair at addr[1], extended per req_unsigned.
  - word: returns all lanes; req_unsigned is ignored.
- Ordering: a load accepted after a store sees the stored data. There is no read-during-write hazard because only one access is outstanding.
- Reset mid-transaction: the pending access is dropped with no memory write and no rsp_valid.
- Widths: the out-of-range check uses the full address. Upper address bits above the index are not aliased.

Test Plan:
- WAIT_CYCLES=0: store word 0xDEADBEEF @0x10, then load word @0x10 → rsp_valid exactly 2 cycles after each accept; rdata=0xDEADBEEF; err=0.
- Store byte 0x80 @0x13, then load byte @0x13 → signed 0xFFFFFF80, unsigned 0x00000080; a word load @0x10 returns 0x80ADBEEF.
- Store half 0x1234 @0x22 over word 0xAAAAAAAA → word load @0x20 = 0x1234AAAA; a signed half load @0x20 returns 0xFFFFAAAA.
- Half @0x21, word @0x22, size 11, word @ DEPTH*4 → each returns err=1, rdata=0; a follow-up load confirms memory is unchanged.
- WAIT_CYCLES=3: accept at edge T → req_ready low for 4 cycles; rsp_valid in the cycle after edge T+4; req_valid held high throughout produces a second accept at edge T+5.
- Assert rst during WAIT of a store → no rsp_valid; a later load of that address returns its old value; req_ready=1 the cycle after rst drops.
